// File: rtl/branch_resolve.sv
//============================================================================
// Module   : branch_resolve
// Purpose  : EX-stage branch resolution. Computes the taken decision and the
//            correct next PC, detects mispredicts, issues a fetch redirect via
//            a valid/ready handshake and then flushes IF/ID for FLUSH_CYCLES.
// Options  : define BRANCH_STATS_EN to build saturating branch/mispredict
//            statistics counters; otherwise both count ports read 0.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_jump_i,
    input  logic [2:0]  funct3_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        br_unsigned_o,
    input  logic        pred_taken_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] target_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        flush_o,
    output logic        stall_o,
    output logic        illegal_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] mispredict_count_o
);

    localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  flush_cnt_q;
    logic [31:0] redirect_pc_q;
    logic        redirect_valid_q;
    logic        flush_q;
    logic        stall_q;
    logic        illegal_q;

    logic        taken_d;
    logic        reserved_d;
    logic        accept_d;
    logic        mispredict_d;
    logic [31:0] correct_pc_d;

    // Unsigned comparison is only used by BLTU/BGEU.
    assign br_unsigned_o = (funct3_i == 3'b110) || (funct3_i == 3'b111);

    // Taken decision from jump flag, funct3 and comparator results.
    always_comb begin
        taken_d    = 1'b0;
        reserved_d = 1'b0;
        if (ex_is_jump_i) begin
            taken_d = 1'b1;
        end else begin
            case (funct3_i)
                3'b000:          taken_d = br_equal_i;
                3'b001:          taken_d = !br_equal_i;
                3'b100, 3'b110:  taken_d = br_less_i;
                3'b101, 3'b111:  taken_d = !br_less_i;
                default:         reserved_d = 1'b1;
            endcase
        end
    end

    // Only instructions presented while IDLE are resolved; wraps modulo 2^32.
    assign accept_d     = ex_valid_i && (state_q == S_IDLE);
    assign mispredict_d = accept_d && (taken_d != pred_taken_i);
    assign correct_pc_d = taken_d ? target_i : (pc_i + 32'd4);

    // Redirect/flush FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            flush_cnt_q      <= 3'd0;
            redirect_pc_q    <= 32'd0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            illegal_q <= accept_d && reserved_d;
            case (state_q)
                S_IDLE: begin
                    if (mispredict_d) begin
                        state_q          <= S_REDIRECT;
                        redirect_pc_q    <= correct_pc_d;
                        redirect_valid_q <= 1'b1;
                        stall_q          <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_q          <= S_FLUSH;
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b1;
                        flush_cnt_q      <= C_FLUSH_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q <= 3'd1) begin
                        state_q     <= S_IDLE;
                        flush_q     <= 1'b0;
                        stall_q     <= 1'b0;
                        flush_cnt_q <= 3'd0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q          <= S_IDLE;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    stall_q          <= 1'b0;
                    flush_cnt_q      <= 3'd0;
                end
            endcase
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign stall_o          = stall_q;
    assign illegal_o        = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    // Saturating statistics counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            if (accept_d && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict_d && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispredict_cnt_q;
`else
    assign branch_count_o     = 32'd0;
    assign mispredict_count_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
//============================================================================
// Module   : tb_branch_resolve
// Purpose  : Self-checking bench for branch_resolve. Expected redirect PCs
//            are queued when a mispredict is driven and popped when the
//            redirect appears. Define BRANCH_STATS_EN to cover statistics.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_branch_resolve;

    localparam int unsigned FC = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_is_jump_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic        br_less_i = 1'b0;
    logic        br_equal_i = 1'b0;
    logic        br_unsigned_o;
    logic        pred_taken_i = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic [31:0] target_i = 32'd0;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i = 1'b1;
    logic        flush_o;
    logic        stall_o;
    logic        illegal_o;
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    branch_resolve #(.FLUSH_CYCLES(FC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i),
        .ex_is_jump_i(ex_is_jump_i), .funct3_i(funct3_i),
        .br_less_i(br_less_i), .br_equal_i(br_equal_i),
        .br_unsigned_o(br_unsigned_o), .pred_taken_i(pred_taken_i),
        .pc_i(pc_i), .target_i(target_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i), .flush_o(flush_o),
        .stall_o(stall_o), .illegal_o(illegal_o),
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Independent reference for the taken decision.
    function automatic logic ref_taken(input logic j, input logic [2:0] f3,
                                       input logic l, input logic e);
        if (j) return 1'b1;
        case (f3)
            3'b000: return e;
            3'b001: return !e;
            3'b100: return l;
            3'b110: return l;
            3'b101: return !l;
            3'b111: return !l;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one instruction; queue its redirect PC when it mispredicts.
    task automatic drive(input logic j, input logic [2:0] f3, input logic l,
                         input logic e, input logic p, input logic [31:0] pc,
                         input logic [31:0] tg);
        logic t;
        ex_valid_i = 1'b1; ex_is_jump_i = j; funct3_i = f3;
        br_less_i = l; br_equal_i = e; pred_taken_i = p;
        pc_i = pc; target_i = tg;
        t = ref_taken(j, f3, l, e);
        if (t != p) exp_q.push_back(t ? tg : pc + 32'd4);
    endtask

    task automatic idle_inputs();
        ex_valid_i = 1'b0; ex_is_jump_i = 1'b0; pred_taken_i = 1'b0;
    endtask

    // Bounded wait for return to IDLE; an expired bound counts as a failure.
    task automatic wait_idle();
        int k;
        for (k = 0; k < 32 && stall_o; k++) @(negedge clk_i);
        if (stall_o) begin
            n_cmp++; n_err++;
            $display("FAIL wait_idle: stall_o=%b required 0 within 32 cycles", stall_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; idle_inputs();
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({redirect_valid_o, flush_o, stall_o, illegal_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got rv/fl/st/il=%b required 0000",
                     {redirect_valid_o, flush_o, stall_o, illegal_o});
        end
        n_cmp++;
        if (redirect_pc_o !== 32'd0 || branch_count_o !== 32'd0 || mispredict_count_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_values: pc=%h bc=%h mc=%h required 0", redirect_pc_o,
                     branch_count_o, mispredict_count_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_bltu_mispredict();
        logic [31:0] e;
        int nf = 0;
        logic ovl = 1'b0;
        redirect_ready_i = 1'b1;
        drive(1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100);
        #1;
        n_cmp++;
        if (br_unsigned_o !== 1'b1) begin
            n_err++; $display("FAIL bltu_unsigned: got %b required 1", br_unsigned_o);
        end
        @(negedge clk_i);
        idle_inputs();
        n_cmp++;
        if ({redirect_valid_o, flush_o, stall_o} !== 3'b101) begin
            n_err++; $display("FAIL bltu_redirect: rv/fl/st=%b required 101",
                              {redirect_valid_o, flush_o, stall_o});
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_pc_o !== e) begin
            n_err++; $display("FAIL bltu_pc: got %h required %h", redirect_pc_o, e);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (redirect_valid_o && flush_o) ovl = 1'b1;
            if (flush_o) nf++;
            if (!stall_o) break;
        end
        n_cmp++;
        if (nf != int'(FC) || ovl) begin
            n_err++; $display("FAIL bltu_flush: flush cycles %0d overlap %b required %0d 0",
                              nf, ovl, FC);
        end
        wait_idle();
    endtask

    task automatic test_correct_predict();
        logic bad = 1'b0;
        drive(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h200, 32'h240);
        #1;
        n_cmp++;
        if (br_unsigned_o !== 1'b0) begin
            n_err++; $display("FAIL bne_unsigned: got %b required 0", br_unsigned_o);
        end
        @(negedge clk_i);
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h300, 32'h800);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            idle_inputs();
            if (redirect_valid_o || flush_o || stall_o) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++; $display("FAIL correct_predict: rv/fl/st activity seen %b required 0", bad);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h500);
        @(negedge clk_i);
        idle_inputs();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== e) begin
            n_err++; $display("FAIL wrap_pc: rv=%b pc=%h required 1 %h",
                              redirect_valid_o, redirect_pc_o, e);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        logic bad = 1'b0;
        int nf = 0;
        logic ovl = 1'b0;
        redirect_ready_i = 1'b0;
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h80, 32'h2000);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (!redirect_valid_o || !stall_o || flush_o || redirect_pc_o !== e) bad = 1'b1;
            if (i == 0) begin
                // Mispredicting instruction while busy must be ignored.
                ex_valid_i = 1'b1; ex_is_jump_i = 1'b1; pred_taken_i = 1'b0;
                pc_i = 32'h900; target_i = 32'h7770;
            end else begin
                idle_inputs();
            end
            redirect_ready_i = (i == 3);
        end
        n_cmp++;
        if (bad) begin
            n_err++; $display("FAIL backpressure_hold: rv/st/pc=%b/%b/%h required 1/1/%h held",
                              redirect_valid_o, stall_o, redirect_pc_o, e);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (redirect_valid_o && flush_o) ovl = 1'b1;
            if (flush_o) nf++;
            if (!stall_o) break;
        end
        n_cmp++;
        if (nf != int'(FC) || ovl || redirect_valid_o) begin
            n_err++; $display("FAIL backpressure_flush: cycles %0d overlap %b rv %b required %0d 0 0",
                              nf, ovl, redirect_valid_o, FC);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_flush();
        logic [31:0] e;
        redirect_ready_i = 1'b1;
        drive(1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h300);
        @(negedge clk_i);
        idle_inputs();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== e) begin
            n_err++; $display("FAIL bge_redirect: rv=%b pc=%h required 1 %h",
                              redirect_valid_o, redirect_pc_o, e);
        end
        @(negedge clk_i);
        n_cmp++;
        if (flush_o !== 1'b1) begin
            n_err++; $display("FAIL first_flush: flush_o=%b required 1", flush_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_cmp++;
        if ({redirect_valid_o, flush_o, stall_o, illegal_o} !== 4'b0000 || redirect_pc_o !== 32'd0) begin
            n_err++; $display("FAIL reset_mid_flush: rv/fl/st/il=%b pc=%h required 0000 0",
                              {redirect_valid_o, flush_o, stall_o, illegal_o}, redirect_pc_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: rv=%b st=%b required 0 0",
                              redirect_valid_o, stall_o);
        end
    endtask

    task automatic test_illegal();
        drive(1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 32'h44, 32'h88);
        @(negedge clk_i);
        idle_inputs();
        n_cmp++;
        if (illegal_o !== 1'b1 || redirect_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++; $display("FAIL illegal_pulse: il=%b rv=%b st=%b required 1 0 0",
                              illegal_o, redirect_valid_o, stall_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (illegal_o !== 1'b0) begin
            n_err++; $display("FAIL illegal_width: il=%b required 0", illegal_o);
        end
    endtask

    task automatic test_stats();
        int nb = 0;
        int nm = 0;
        rst_i = 1'b1; idle_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // Instructions 1 and 3 mispredict (taken but predicted not-taken).
            drive(1'b0, 3'b000, 1'b0, (i == 1 || i == 3), (i != 1 && i != 3) ? 1'b0 : 1'b0,
                  32'h100 + 32'(i * 4), 32'h600);
            nb++;
            if (i == 1 || i == 3) nm++;
            @(negedge clk_i);
            idle_inputs();
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            wait_idle();
        end
`ifdef BRANCH_STATS_EN
        n_cmp++;
        if (branch_count_o !== 32'(nb) || mispredict_count_o !== 32'(nm)) begin
            n_err++; $display("FAIL stats_counts: bc=%0d mc=%0d required %0d %0d",
                              branch_count_o, mispredict_count_o, nb, nm);
        end
        force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_cnt_q;
        drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h10, 32'h20);
        @(negedge clk_i);
        idle_inputs();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        wait_idle();
        n_cmp++;
        if (mispredict_count_o !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL stats_saturate: mc=%h required FFFFFFFF", mispredict_count_o);
        end
`else
        n_cmp++;
        if (branch_count_o !== 32'd0 || mispredict_count_o !== 32'd0) begin
            n_err++; $display("FAIL stats_tied: bc=%h mc=%h required 0 0 (nb=%0d nm=%0d)",
                              branch_count_o, mispredict_count_o, nb, nm);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_bltu_mispredict();
        test_correct_predict();
        test_wrap();
        test_backpressure();
        test_reset_mid_flush();
        test_illegal();
        test_stats();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
